// File: rtl/l2_bus_pkg.sv
// -----------------------------------------------------------------------------
// l2_bus_pkg
// Shared definitions for the L2 shared-bus arbiter:
//   - operation codes carried on req_op / bus_op (ASCII letters)
//   - snoop reply encodings and the priority merge used to combine them
//   - arbiter FSM state type
// -----------------------------------------------------------------------------
package l2_bus_pkg;

  localparam logic [7:0] OP_READ   = 8'h52;  // "R"
  localparam logic [7:0] OP_WRITE  = 8'h57;  // "W"
  localparam logic [7:0] OP_MODIFY = 8'h4D;  // "M"
  localparam logic [7:0] OP_INVAL  = 8'h49;  // "I"

  localparam logic [1:0] SNOOP_NOHIT = 2'b00;
  localparam logic [1:0] SNOOP_HIT   = 2'b01;
  localparam logic [1:0] SNOOP_HITM  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SNOOP = 2'd2,
    ST_XFER  = 2'd3
  } arb_state_t;

  // HITM beats HIT beats NOHIT; the reserved code 11 never matches either
  // of the first two tests, so it falls through as NOHIT.
  function automatic logic [1:0] snoop_merge(input logic [1:0] acc,
                                             input logic [1:0] reply);
    if (acc == SNOOP_HITM || reply == SNOOP_HITM) return SNOOP_HITM;
    if (acc == SNOOP_HIT  || reply == SNOOP_HIT)  return SNOOP_HIT;
    return SNOOP_NOHIT;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Purely combinational round-robin picker: scans req upward starting at
// index 'start' (wrapping at N) and returns the first set bit.
// Ports:
//   req    [N-1:0]  request vector
//   start  [IW-1:0] first index to examine (must be < N)
//   winner [N-1:0]  one-hot winner, all zero when req is zero
//   idx    [IW-1:0] index of the winner, zero when req is zero
// -----------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic found;
    int   pos;
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[pos]) begin
        found       = 1'b1;
        winner[pos] = 1'b1;
        idx         = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// -----------------------------------------------------------------------------
// shared_bus_arbiter
// Round-robin arbiter for NUM_REQ L2 caches sharing one bus. Each
// transaction runs GRANT -> SNOOP -> XFER; the snoop replies of all
// non-owners are merged and reported once per transaction.
//
// Optional feature: define ARB_TIMEOUT_EN to add an XFER watchdog
// (TIMEOUT cycles) and the timeout_err output port.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req            per-requester level request
//   req_op         per-requester 8-bit op code (byte i belongs to requester i)
//   done           per-requester transfer-complete pulse
//   snoop_result   per-cache 2-bit snoop reply
//   gnt            one-hot grant, zero in IDLE
//   bus_op         op code of the current owner, zero in IDLE
//   owner          index of the current (or most recent) owner
//   snoop_valid    one-cycle pulse, first XFER cycle
//   snoop_summary  merged snoop reply, held until the next snoop_valid
//   busy           high outside IDLE
//   timeout_err    watchdog expiry pulse (ARB_TIMEOUT_EN only)
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no owner; arbitrate whenever any req is high
// GRANT  | single cycle, gnt already asserted for the new owner
// SNOOP  | SNOOP_CYCLES cycles; replies sampled in the last one
// XFER   | data transfer, ends on done[owner] (or watchdog expiry)
// -----------------------------------------------------------------------------
module shared_bus_arbiter
  import l2_bus_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int SNOOP_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       req_op,
  input  logic [NUM_REQ-1:0]         done,
  input  logic [NUM_REQ*2-1:0]       snoop_result,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [7:0]                 bus_op,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       snoop_valid,
  output logic [1:0]                 snoop_summary,
  output logic                       busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                       timeout_err
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || SNOOP_CYCLES < 1 || SNOOP_CYCLES > 15 ||
      TIMEOUT < 1) begin : g_bad_params
    $error("shared_bus_arbiter: parameter out of range");
  end

  arb_state_t         state;
  logic [IW-1:0]      last_owner;
  logic [IW-1:0]      rr_start;
  logic [IW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [3:0]         snoop_cnt;
  logic [1:0]         snoop_comb;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WD_LOAD = TW'(TIMEOUT - 1);
  logic [TW-1:0] wd_cnt;
`endif

  assign rr_start = (last_owner == LAST_IDX) ? '0 : last_owner + IW'(1);
  assign busy     = (state != ST_IDLE);

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req    (req),
    .start  (rr_start),
    .winner (win_onehot),
    .idx    (win_idx)
  );

  // The owner's own reply is excluded: it cannot hit on its own request.
  always_comb begin
    snoop_comb = SNOOP_NOHIT;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) != owner) snoop_comb = snoop_merge(snoop_comb, snoop_result[2*i +: 2]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      gnt           <= '0;
      bus_op        <= '0;
      owner         <= '0;
      snoop_valid   <= 1'b0;
      snoop_summary <= SNOOP_NOHIT;
      snoop_cnt     <= '0;
      last_owner    <= LAST_IDX;
`ifdef ARB_TIMEOUT_EN
      wd_cnt        <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      snoop_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            owner  <= win_idx;
            gnt    <= win_onehot;
            bus_op <= req_op[8*win_idx +: 8];
            state  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          snoop_cnt <= 4'(SNOOP_CYCLES - 1);
          state     <= ST_SNOOP;
        end
        ST_SNOOP: begin
          if (snoop_cnt == '0) begin
            snoop_summary <= snoop_comb;
            snoop_valid   <= 1'b1;
            state         <= ST_XFER;
`ifdef ARB_TIMEOUT_EN
            wd_cnt        <= WD_LOAD;
`endif
          end else begin
            snoop_cnt <= snoop_cnt - 4'd1;
          end
        end
        ST_XFER: begin
          if (done[owner]) begin
            gnt        <= '0;
            bus_op     <= '0;
            last_owner <= owner;
            state      <= ST_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wd_cnt == '0) begin
            gnt         <= '0;
            bus_op      <= '0;
            last_owner  <= owner;
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt - TW'(1);
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_bus_arbiter
// Directed bench for shared_bus_arbiter (NUM_REQ=4, SNOOP_CYCLES=2,
// TIMEOUT=8). Expected grants and snoop summaries are queued as stimulus is
// issued; a monitor pops and compares whenever a new grant or snoop_valid
// appears. Cycle-exact behaviour is checked inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_shared_bus_arbiter;
  import l2_bus_pkg::*;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*8-1:0] req_op;
  logic [N-1:0]   done;
  logic [N*2-1:0] snoop_result;
  logic [N-1:0]   gnt;
  logic [7:0]     bus_op;
  logic [1:0]     owner;
  logic           snoop_valid;
  logic [1:0]     snoop_summary;
  logic           busy;
`ifdef ARB_TIMEOUT_EN
  logic           timeout_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] gnt;
    logic [7:0]   op;
    logic [1:0]   owner;
  } grant_t;

  grant_t     exp_grant_q[$];
  logic [1:0] exp_snoop_q[$];

  shared_bus_arbiter #(
    .NUM_REQ      (N),
    .SNOOP_CYCLES (2),
    .TIMEOUT      (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_op        (req_op),
    .done          (done),
    .snoop_result  (snoop_result),
    .gnt           (gnt),
    .bus_op        (bus_op),
    .owner         (owner),
    .snoop_valid   (snoop_valid),
    .snoop_summary (snoop_summary),
    .busy          (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout_err   (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_txn(input logic [N-1:0] g, input logic [7:0] op,
                            input logic [1:0] own, input logic [1:0] snp);
    grant_t t;
    t.gnt = g; t.op = op; t.owner = own;
    exp_grant_q.push_back(t);
    exp_snoop_q.push_back(snp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    done = '0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Steps until snoop_valid is seen (first XFER cycle), bounded.
  task automatic wait_snoop_valid(input string name);
    int k;
    k = 0;
    while (snoop_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    if (snoop_valid !== 1'b1) check(name, 32'(snoop_valid), 32'd1);
  endtask

  // Monitor: compares every new grant and every snoop_valid against the queues.
  initial begin : monitor
    grant_t       g;
    logic [1:0]   s;
    logic [N-1:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (gnt != '0 && prev == '0) begin
        if (exp_grant_q.size() == 0) begin
          check("unexpected_grant", 32'(gnt), 32'd0);
        end else begin
          g = exp_grant_q.pop_front();
          check("grant_onehot", 32'(gnt), 32'(g.gnt));
          check("grant_bus_op", 32'(bus_op), 32'(g.op));
          check("grant_owner", 32'(owner), 32'(g.owner));
        end
      end
      if (snoop_valid === 1'b1) begin
        if (exp_snoop_q.size() == 0) begin
          check("unexpected_snoop_valid", 32'(snoop_valid), 32'd0);
        end else begin
          s = exp_snoop_q.pop_front();
          check("snoop_summary", 32'(snoop_summary), 32'(s));
        end
      end
      prev = gnt;
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: bench did not finish, got running, expected done");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    logic [7:0] sr_tab  [4];
    logic [1:0] exp_tab [4];
    logic [7:0] op_tab  [4];

    rst_n = 1'b0;
    req = '0;
    done = '0;
    snoop_result = '0;
    req_op = {8'h49, 8'h4D, 8'h57, 8'h52};  // req 3..0 = I, M, W, R
    op_tab = '{8'h52, 8'h57, 8'h4D, 8'h49};

    // Reset state
    step(2);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_bus_op", 32'(bus_op), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_snoop_valid", 32'(snoop_valid), 32'd0);
    check("rst_snoop_summary", 32'(snoop_summary), 32'd0);
`ifdef ARB_TIMEOUT_EN
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
`endif
    rst_n = 1'b1;

    // Single request, cycle-exact walk through the transaction
    req = 4'b0001;
    expect_txn(4'b0001, 8'h52, 2'd0, 2'b00);
    step();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_bus_op", 32'(bus_op), 32'h52);
    req = '0;
    step();
    check("t1_no_early_sv_a", 32'(snoop_valid), 32'd0);
    step();
    check("t1_no_early_sv_b", 32'(snoop_valid), 32'd0);
    step();
    check("t1_snoop_valid", 32'(snoop_valid), 32'd1);
    check("t1_gnt_held", 32'(gnt), 32'h1);
    step();
    check("t1_sv_one_cycle", 32'(snoop_valid), 32'd0);
    done = 4'b0001;
    step();
    done = '0;
    check("t1_release_gnt", 32'(gnt), 32'd0);
    check("t1_release_busy", 32'(busy), 32'd0);
    check("t1_release_bus_op", 32'(bus_op), 32'd0);

    // Round robin with all requesters held: 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) expect_txn(4'(1 << (i % 4)), op_tab[i % 4], 2'(i % 4), 2'b00);
    for (int i = 0; i < 5; i++) begin
      wait_snoop_valid("t2_reach_xfer");
      done = 4'(1 << (i % 4));
      step();
      done = '0;
      check("t2_idle_gap", 32'(busy), 32'd0);
      if (i == 4) req = '0;
      step();
      check("t2_back_to_back", 32'(gnt != '0), (i < 4) ? 32'd1 : 32'd0);
    end

    // Snoop combining with owner 2 (owner's own HITM must be ignored)
    do_reset();
    sr_tab  = '{8'b01101000, 8'b01100000, 8'b00100000, 8'b11100011};
    exp_tab = '{2'b10, 2'b01, 2'b00, 2'b00};
    for (int j = 0; j < 4; j++) begin
      snoop_result = sr_tab[j];
      req = 4'b0100;
      expect_txn(4'b0100, 8'h4D, 2'd2, exp_tab[j]);
      step();
      req = '0;
      wait_snoop_valid("t3_reach_xfer");
      step();
      done = 4'b0100;
      step();
      done = '0;
      check("t3_summary_hold", 32'(snoop_summary), 32'(exp_tab[j]));
      step();
    end
    snoop_result = '0;

    // Early and stray done
    do_reset();
    req = 4'b0010;
    expect_txn(4'b0010, 8'h57, 2'd1, 2'b00);
    step();                       // GRANT
    req = '0;
    done = 4'b0010;
    step();                       // SNOOP, done in GRANT ignored
    check("t4_done_in_grant", 32'(gnt), 32'h2);
    step();                       // last SNOOP cycle, done ignored
    check("t4_done_in_snoop", 32'(busy), 32'd1);
    step();                       // XFER
    check("t4_snoop_completes", 32'(snoop_valid), 32'd1);
    done = 4'b1000;
    step();
    check("t4_stray_done_gnt", 32'(gnt), 32'h2);
    check("t4_stray_done_busy", 32'(busy), 32'd1);
    check("t4_stray_done_op", 32'(bus_op), 32'h57);
    done = '0;
    step();
    done = 4'b0010;
    step();
    done = '0;
    check("t4_owner_done_gnt", 32'(gnt), 32'd0);
    check("t4_owner_done_busy", 32'(busy), 32'd0);
    done = 4'b1111;
    step(3);
    done = '0;
    check("t4_done_in_idle", 32'(busy), 32'd0);

    // Reset in the middle of XFER
    do_reset();
    snoop_result = 8'b00000100;   // requester 1 HIT
    req = 4'b0001;
    expect_txn(4'b0001, 8'h52, 2'd0, 2'b01);
    step();
    req = '0;
    wait_snoop_valid("t5_reach_xfer");
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_gnt", 32'(gnt), 32'd0);
    check("t5_rst_bus_op", 32'(bus_op), 32'd0);
    check("t5_rst_owner", 32'(owner), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_snoop_summary", 32'(snoop_summary), 32'd0);
    step();
    rst_n = 1'b1;
    snoop_result = '0;
    req = 4'b0110;
    expect_txn(4'b0010, 8'h57, 2'd1, 2'b00);
    expect_txn(4'b0100, 8'h4D, 2'd2, 2'b00);
    step();
    check("t5_first_after_rst", 32'(gnt), 32'h2);
    req = 4'b0100;
    wait_snoop_valid("t5_reach_xfer_b");
    done = 4'b0010;
    step();
    done = '0;
    step();
    check("t5_second_grant", 32'(gnt), 32'h4);
    req = '0;
    wait_snoop_valid("t5_reach_xfer_c");
    done = 4'b0100;
    step();
    done = '0;

`ifdef ARB_TIMEOUT_EN
    // Watchdog: last owner 2, so requester 3 wins; no done arrives
    req = 4'b1001;
    expect_txn(4'b1000, 8'h49, 2'd3, 2'b00);
    expect_txn(4'b0001, 8'h52, 2'd0, 2'b00);
    step();
    req = 4'b0001;
    wait_snoop_valid("t6_reach_xfer");
    for (int k = 1; k < 8; k++) begin
      step();
      check("t6_no_early_timeout", 32'(timeout_err), 32'd0);
    end
    step();
    check("t6_timeout_err", 32'(timeout_err), 32'd1);
    check("t6_timeout_gnt", 32'(gnt), 32'd0);
    check("t6_timeout_busy", 32'(busy), 32'd0);
    step();
    check("t6_timeout_pulse", 32'(timeout_err), 32'd0);
    check("t6_next_grant", 32'(gnt), 32'h1);
    req = '0;
    wait_snoop_valid("t6_reach_xfer_b");
    done = 4'b0001;
    step();
    done = '0;
`else
    // Without the watchdog XFER waits for done indefinitely
    req = 4'b0001;
    expect_txn(4'b0001, 8'h52, 2'd0, 2'b00);
    step();
    req = '0;
    wait_snoop_valid("t6_reach_xfer");
    step(100);
    check("t6_xfer_holds_gnt", 32'(gnt), 32'h1);
    check("t6_xfer_holds_busy", 32'(busy), 32'd1);
    done = 4'b0001;
    step();
    done = '0;
    check("t6_done_release", 32'(busy), 32'd0);
`endif

    step(3);
    check("grant_queue_drained", 32'(exp_grant_q.size()), 32'd0);
    check("snoop_queue_drained", 32'(exp_snoop_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
